// File: rtl/csr_apb_slave.sv
// APB3 slave for the ALU CSR block: decodes six CSR addresses, strobes the
// operand registers, feeds FIFO_IN, drains FIFO_OUT and counts bus errors.
`timescale 1ns/1ps

module csr_apb_slave #(
    parameter int                    ADDR_W    = 3,
    parameter int                    DATA_W    = 32,
    parameter int                    RES_W     = 25,
    parameter int                    OP_W      = 2,
    parameter logic [2**OP_W-1:0]    VALID_OPS = 4'b0110,
    parameter int                    START_POS = 2,
    parameter int                    RD_WAIT   = 1,
    parameter int                    ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] prdata,
    output logic [2:0]        wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              full_in,
    output logic              w_en_in,
    input  logic              empty_out,
    input  logic [RES_W-1:0]  final_result,
    input  logic [RES_W-1:0]  fifo_out_status,
    output logic              r_en_out,
    output logic [1:0]        fsm_state
);

    // APB handshake: a transfer is set up when psel=1 and penable=0, then held
    // with penable=1; it completes in the cycle where psel=1 and pready=1.
    // pslverr and prdata are meaningful only in that completion cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_RES    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_ERRCNT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_LIMIT  = ADDR_W'(6);
    localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_write;
    logic                acc_err;
    logic [3:0]          wait_cnt;
    logic [ERR_W-1:0]    err_cnt;

    logic                is_reg;
    logic                is_res;
    logic                op_ok;
    logic                setup_err;
    logic [3:0]          setup_wait;
    logic                done;
    logic                ok_done;

    // Error decode works on the live bus; APB keeps it stable through SETUP.
    always_comb begin
        is_reg    = (paddr < ADDR_W'(3));
        is_res    = (paddr == A_RES);
        op_ok     = VALID_OPS[pwdata[OP_W-1:0]];
        setup_err = 1'b0;
        if (paddr >= A_LIMIT)
            setup_err = 1'b1;
        if (!pwrite && is_reg)
            setup_err = 1'b1;
        if (pwrite && !is_reg)
            setup_err = 1'b1;
        if (pwrite && is_reg && full_in)
            setup_err = 1'b1;
        if (!pwrite && is_res && empty_out)
            setup_err = 1'b1;
        if (pwrite && (paddr == A_CTRL) && !op_ok)
            setup_err = 1'b1;
        setup_wait = (!pwrite && !setup_err) ? 4'(RD_WAIT) : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pready     = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable)
                    state_next = SETUP;
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                pready = (wait_cnt == 4'd0);
                if (!psel || wait_cnt == 4'd0)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fsm_state = state;
    assign pslverr   = pready && acc_err;
    assign done      = pready && psel;
    assign ok_done   = done && !acc_err;
    assign r_en_out  = pready && !acc_err && !acc_write && (acc_addr == A_RES);

    always_comb begin
        wr_en = 3'b000;
        if (ok_done && acc_write && acc_addr < ADDR_W'(3))
            wr_en = 3'b001 << acc_addr[1:0];
    end

    always_comb begin
        prdata = '0;
        if (pready && !acc_err && !acc_write) begin
            case (acc_addr)
                A_RES:    prdata = DATA_W'(final_result);
                A_STATUS: prdata = DATA_W'({empty_out, full_in, fifo_out_status});
                A_ERRCNT: prdata = DATA_W'(err_cnt);
                default:  prdata = '0;
            endcase
        end
    end

    // Transfer context; the wait counter only moves while psel is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_addr  <= '0;
            acc_write <= 1'b0;
            acc_err   <= 1'b0;
            wr_data   <= '0;
            wait_cnt  <= 4'd0;
        end else if (state == SETUP) begin
            acc_addr  <= paddr;
            acc_write <= pwrite;
            acc_err   <= setup_err;
            wr_data   <= pwdata;
            wait_cnt  <= setup_wait;
        end else if (state == ACCESS && psel && wait_cnt != 4'd0) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            w_en_in <= 1'b0;
        else
            w_en_in <= ok_done && acc_write && (acc_addr == A_CTRL) && wr_data[START_POS];
    end

    // Saturating error count; a successful ERRCNT read clears it after returning it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (done && acc_err) begin
            if (err_cnt != ERR_MAX)
                err_cnt <= err_cnt + ERR_W'(1);
        end else if (ok_done && !acc_write && acc_addr == A_ERRCNT)
            err_cnt <= '0;
    end

endmodule

// File: tb/tb_csr_apb_slave.sv
// Self-checking bench for csr_apb_slave: APB driver tasks, expected-result
// queue popped at each completion, abort and asynchronous-reset scenarios.
`timescale 1ns/1ps

module tb_csr_apb_slave;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 32;
    localparam int RES_W   = 25;
    localparam int RD_WAIT = 1;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = 3;
    localparam logic [3:0] VALID_OPS = 4'b0110;
    // {waits[3:0], err, wr_en[2:0], r_en, w_en_in_next, prdata[31:0]}
    localparam int EW = 42;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;
    logic [2:0]        wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full_in;
    logic              w_en_in;
    logic              empty_out;
    logic [RES_W-1:0]  final_result;
    logic [RES_W-1:0]  fifo_out_status;
    logic              r_en_out;
    logic [1:0]        fsm_state;

    logic [EW-1:0] exp_q[$];
    int tests  = 0;
    int failed = 0;
    int err_model = 0;

    csr_apb_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .OP_W(2),
        .VALID_OPS(VALID_OPS), .START_POS(2), .RD_WAIT(RD_WAIT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .prdata(prdata), .wr_en(wr_en), .wr_data(wr_data), .full_in(full_in),
        .w_en_in(w_en_in), .empty_out(empty_out), .final_result(final_result),
        .fifo_out_status(fifo_out_status), .r_en_out(r_en_out), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        logic          err;
        logic [3:0]    exp_waits;
        logic [2:0]    exp_wr;
        logic          exp_ren;
        logic          exp_wen;
        logic [31:0]   exp_rd;
        logic [31:0]   stat;
        logic [EW-1:0] e;
        int            waits;

        // Reference model of the CSR map
        if (wr) err = (addr >= 3) || full_in || (addr == 0 && !VALID_OPS[data[1:0]]);
        else    err = (addr < 3) || (addr >= 6) || (addr == 3 && empty_out);
        exp_waits = (!wr && !err) ? 4'(1 + RD_WAIT) : 4'd1;
        exp_wr    = (wr && !err) ? (3'b001 << addr[1:0]) : 3'b000;
        exp_ren   = !wr && !err && addr == 3;
        exp_wen   = wr && !err && addr == 0 && data[2];
        stat      = '0;
        stat[RES_W+1:0] = {empty_out, full_in, fifo_out_status};
        exp_rd    = '0;
        if (!wr && !err) begin
            if (addr == 3)      exp_rd = 32'(final_result);
            else if (addr == 4) exp_rd = stat;
            else                exp_rd = 32'(err_model);
        end
        exp_q.push_back({exp_waits, err, exp_wr, exp_ren, exp_wen, exp_rd});

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!pready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check("pready_latency", 64'(waits), 64'(e[41:38]));
        check("pslverr", 64'(pslverr), 64'(e[37]));
        check("wr_en", 64'(wr_en), 64'(e[36:34]));
        check("r_en_out", 64'(r_en_out), 64'(e[33]));
        check("prdata", 64'(prdata), 64'(e[31:0]));
        check("w_en_in_early", 64'(w_en_in), 64'd0);
        if (wr) check("wr_data", 64'(wr_data), 64'(data));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        check("w_en_in", 64'(w_en_in), 64'(e[32]));
        check("pready_drop", 64'(pready), 64'd0);
        check("wr_en_single", 64'(wr_en), 64'd0);
        @(negedge clk);
        check("w_en_in_one_shot", 64'(w_en_in), 64'd0);

        if (err) begin
            if (err_model < ERR_MAX) err_model++;
        end else if (!wr && addr == 5) begin
            err_model = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; full_in = 1'b0; empty_out = 1'b0;
        final_result = '0; fifo_out_status = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 64'(pready), 64'd0);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_w_en_in", 64'(w_en_in), 64'd0);
        check("rst_r_en_out", 64'(r_en_out), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
        rst_n = 1'b1;

        // Legal writes and reads
        apb_xfer(1'b1, 3'd0, 32'h5);
        apb_xfer(1'b1, 3'd1, $urandom);
        apb_xfer(1'b1, 3'd2, $urandom);
        apb_xfer(1'b1, 3'd0, 32'h1);
        final_result = 25'h1ABCDEF;
        apb_xfer(1'b0, 3'd3, 32'h0);
        fifo_out_status = RES_W'($urandom);
        full_in = 1'b1;
        apb_xfer(1'b0, 3'd4, 32'h0);
        full_in = 1'b0; empty_out = 1'b1;
        apb_xfer(1'b0, 3'd4, 32'h0);
        empty_out = 1'b0;

        // Illegal accesses
        apb_xfer(1'b1, 3'd0, 32'h7);
        apb_xfer(1'b0, 3'd1, 32'h0);
        apb_xfer(1'b1, 3'd7, 32'h12);
        apb_xfer(1'b0, 3'd6, 32'h0);
        apb_xfer(1'b1, 3'd4, 32'h3);
        full_in = 1'b1;
        apb_xfer(1'b1, 3'd1, 32'hCAFE);
        full_in = 1'b0; empty_out = 1'b1;
        apb_xfer(1'b0, 3'd3, 32'h0);
        empty_out = 1'b0;

        // Error counter saturation and clear-on-read
        apb_xfer(1'b0, 3'd5, 32'h0);
        apb_xfer(1'b0, 3'd5, 32'h0);
        for (int i = 0; i < 5; i++)
            apb_xfer(1'b0, 3'($urandom_range(0, 2)), 32'h0);
        apb_xfer(1'b0, 3'd5, 32'h0);
        apb_xfer(1'b0, 3'd5, 32'h0);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            full_in = 1'($urandom_range(0, 1));
            empty_out = 1'($urandom_range(0, 1));
            final_result = RES_W'($urandom);
            fifo_out_status = RES_W'($urandom);
            apb_xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
        end
        full_in = 1'b0; empty_out = 1'b0;
        apb_xfer(1'b0, 3'd5, 32'h0);

        // Abort a RES read while it is waiting
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd3;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("abort_in_access", 64'(fsm_state), 64'd2);
        check("abort_wait_pready", 64'(pready), 64'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_pready", 64'(pready), 64'd0);
        check("abort_r_en_out", 64'(r_en_out), 64'd0);
        @(posedge clk); #1;
        check("abort_idle", 64'(fsm_state), 64'd0);
        check("abort_pready_after", 64'(pready), 64'd0);
        check("abort_r_en_after", 64'(r_en_out), 64'd0);
        apb_xfer(1'b0, 3'd5, 32'h0);

        // Asynchronous reset during ACCESS of a CTRL start write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 32'h5;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_pready", 64'(pready), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pready", 64'(pready), 64'd0);
        check("arst_pslverr", 64'(pslverr), 64'd0);
        check("arst_prdata", 64'(prdata), 64'd0);
        check("arst_wr_en", 64'(wr_en), 64'd0);
        check("arst_wr_data", 64'(wr_data), 64'd0);
        check("arst_w_en_in", 64'(w_en_in), 64'd0);
        check("arst_r_en_out", 64'(r_en_out), 64'd0);
        check("arst_state", 64'(fsm_state), 64'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_w_en_in", 64'(w_en_in), 64'd0);
        err_model = 0;
        apb_xfer(1'b0, 3'd5, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
